byte_serializer: RTL and testbench

//  Parallel-to-serial output stage fed by an 8-bit bus. Accepts one word per

---
 rtl/byte_serializer_if.sv | 19 +
 rtl/byte_serializer.sv | 144 ++++++++++++++
 tb/tb_byte_serializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// Handshake and serial-output bundle for byte_serializer.
//  in_data/in_valid : upstream word and its valid strobe (master drives)
//  in_ready         : serializer can take a word (slave drives)
//  q/busy/done      : serial line, frame-in-progress flag, frame-complete pulse
interface byte_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             q;
  logic             busy;
  logic             done;

  modport master (output in_data, output in_valid,
                  input  in_ready, input q, input busy, input done);
  modport slave  (input  in_data, input in_valid,
                  output in_ready, output q, output busy, output done);
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial output stage with optional start/stop framing.
//  clk   : clock, all state updates on posedge
//  rstb  : asynchronous active-low reset
//  bus   : slave side of byte_serializer_if (in_data/in_valid/in_ready in,
//          registered q/busy/done out; q idles high)
module byte_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned FRAMED    = 1
) (
  input  logic               clk,
  input  logic               rstb,
  byte_serializer_if.slave   bus
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_q, w_q_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ready, r_busy;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_div_cnt, w_div_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic             w_accept;
  logic             w_period_end;

  // Bit that goes on the line next, taken from the head of the shift register.
  function automatic logic f_head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just emitted so the next one sits at the head.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign w_accept     = bus.in_valid && r_ready;
  assign w_period_end = (r_div_cnt == DIV_LAST);

  // Next-state and next-output decode; q is loaded with the value of the
  // bit period being entered so it lands one cycle after the deciding edge.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = '0;
    if (r_state != S_IDLE && !w_period_end) begin
      w_div_nxt = r_div_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_q_nxt = 1'b1;
        if (w_accept) begin
          w_bit_nxt = '0;
          if (FRAMED != 0) begin
            w_state_nxt = S_START;
            w_q_nxt     = 1'b0;
            w_shift_nxt = bus.in_data;
          end else begin
            w_state_nxt = S_DATA;
            w_q_nxt     = f_head(bus.in_data);
            w_shift_nxt = f_shift(bus.in_data);
          end
        end
      end
      S_START: begin
        if (w_period_end) begin
          w_state_nxt = S_DATA;
          w_q_nxt     = f_head(r_shift);
          w_shift_nxt = f_shift(r_shift);
        end
      end
      S_DATA: begin
        if (w_period_end) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt = '0;
            w_q_nxt   = 1'b1;
            if (FRAMED != 0) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bit_cnt + BIT_W'(1);
            w_q_nxt     = f_head(r_shift);
            w_shift_nxt = f_shift(r_shift);
          end
        end
      end
      S_STOP: begin
        if (w_period_end) begin
          w_state_nxt = S_IDLE;
          w_q_nxt     = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_q_nxt     = 1'b1;
      end
    endcase
  end

  // State and datapath registers; ready/busy are decoded from the next state
  // so they are registered yet track the state register exactly.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_q       <= 1'b1;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_shift   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_done    <= w_done_nxt;
      r_ready   <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_shift   <= w_shift_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.q        = r_q;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: two instances (defaults, and DIV=1/MSB-first/
// unframed) driven from a vector table, hand-written corner sequences and
// random words checked against a bit-list reference model.
module tb_byte_serializer;

  typedef bit bitq_t[$];

  typedef struct {
    int         sel;       // 0: default instance, 1: fast MSB-first unframed
    logic [7:0] word;
    logic [7:0] data_after;
    bit         hold;      // keep in_valid high after the accept
    logic [9:0] exp_seq;   // transmitted bits, [0] goes out first
    int         gap_after;
  } vec_t;

  logic clk = 1'b0;
  logic rstb0;
  logic rstb1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  byte_serializer_if #(.WIDTH(8)) bus0 ();
  byte_serializer_if #(.WIDTH(8)) bus1 ();

  byte_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(0), .FRAMED(1)) dut0 (
    .clk (clk),
    .rstb(rstb0),
    .bus (bus0)
  );

  byte_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1), .FRAMED(0)) dut1 (
    .clk (clk),
    .rstb(rstb1),
    .bus (bus1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int sel);
    return (sel != 0) ? 1 : 4;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin
      bus1.in_valid = v;
      bus1.in_data  = d;
    end else begin
      bus0.in_valid = v;
      bus0.in_data  = d;
    end
  endtask

  task automatic chk_outs(input int sel, input string name, input logic q,
                          input logic busy, input logic done, input logic rdy);
    if (sel != 0) begin
      chk({name, "_q"},     bus1.q,        q);
      chk({name, "_busy"},  bus1.busy,     busy);
      chk({name, "_done"},  bus1.done,     done);
      chk({name, "_ready"}, bus1.in_ready, rdy);
    end else begin
      chk({name, "_q"},     bus0.q,        q);
      chk({name, "_busy"},  bus0.busy,     busy);
      chk({name, "_done"},  bus0.done,     done);
      chk({name, "_ready"}, bus0.in_ready, rdy);
    end
  endtask

  // Reference: the ordered list of line values for one word, one entry per bit period.
  function automatic bitq_t model_bits(input int sel, input logic [7:0] w);
    bitq_t b;
    bit framed = (sel == 0);
    bit msb    = (sel == 1);
    if (framed) b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(w[msb ? 7 - i : i]);
    if (framed) b.push_back(1'b1);
    return b;
  endfunction

  function automatic bitq_t seq_to_q(input logic [9:0] s, input int n);
    bitq_t b;
    for (int i = 0; i < n; i++) b.push_back(s[i]);
    return b;
  endfunction

  // Enter at a negedge with the DUT idle; leave at the negedge of the done cycle.
  task automatic run_frame(input int sel, input logic [7:0] word,
                           input logic [7:0] data_after, input bit hold,
                           input bitq_t bits);
    int dv = div_of(sel);
    chk("pre_ready", (sel != 0) ? bus1.in_ready : bus0.in_ready, 1'b1);
    set_in(sel, 1'b1, word);
    @(posedge clk);
    #1;
    set_in(sel, hold, data_after);
    for (int k = 0; k < bits.size() * dv; k++) begin
      @(negedge clk);
      chk_outs(sel, $sformatf("frame%0d_c%0d", sel, k), bits[k / dv], 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk_outs(sel, $sformatf("frame%0d_end", sel), 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle(input int sel, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_outs(sel, $sformatf("idle%0d", sel), 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    vec_t  tbl[6];
    bitq_t b;
    tbl[0] = '{0, 8'hA5, 8'h00, 1'b0, 10'b1101001010, 2};
    tbl[1] = '{0, 8'h3C, 8'h00, 1'b0, 10'b1001111000, 1};
    tbl[2] = '{0, 8'h01, 8'hFF, 1'b1, 10'b1000000010, 0};
    tbl[3] = '{0, 8'hFF, 8'h00, 1'b0, 10'b1111111110, 1};
    tbl[4] = '{1, 8'hC1, 8'h00, 1'b0, 10'h083,        1};
    tbl[5] = '{1, 8'h12, 8'h00, 1'b0, 10'h048,        2};

    rstb0 = 1'b0;
    rstb1 = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);

    // Reset with the clock running.
    repeat (3) begin
      @(negedge clk);
      chk_outs(0, "reset0", 1'b1, 1'b0, 1'b0, 1'b1);
      chk_outs(1, "reset1", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    rstb0 = 1'b1;
    rstb1 = 1'b1;
    idle(0, 1);
    idle(1, 1);

    // Vector table: entries 2/3 run back-to-back with in_valid held high.
    foreach (tbl[i]) begin
      run_frame(tbl[i].sel, tbl[i].word, tbl[i].data_after, tbl[i].hold,
                seq_to_q(tbl[i].exp_seq, (tbl[i].sel != 0) ? 8 : 10));
      if (tbl[i].gap_after > 0) idle(tbl[i].sel, tbl[i].gap_after);
    end

    // Reset during the third data bit aborts the frame with no done pulse.
    b = model_bits(0, 8'h55);
    set_in(0, 1'b1, 8'h55);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("abort_q", bus0.q, b[k / 4]);
    end
    #2;
    rstb0 = 1'b0;
    #1;
    chk_outs(0, "abort_now", 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk_outs(0, "abort_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    rstb0 = 1'b1;
    idle(0, 2);
    run_frame(0, 8'h0F, 8'h00, 1'b0, model_bits(0, 8'h0F));
    idle(0, 1);

    // Random words with random idle gaps (gap 0 gives back-to-back frames).
    for (int sel = 0; sel < 2; sel++) begin
      for (int r = 0; r < 10; r++) begin
        int         gap;
        logic [7:0] w;
        gap = int'($urandom_range(0, 2));
        w   = 8'($urandom);
        idle(sel, gap);
        run_frame(sel, w, 8'($urandom), 1'b0, model_bits(sel, w));
      end
      idle(sel, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
